bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares port A of the 256x8 `dual_port_ram` between two requesters.
- Typical pairing: requester 0 is a loader/writer, requester 1 is the LED display reader.
- Sits between the requesters and the RAM, with the RAM clocked by the same clk (e.g. clk2 after clk10hz).
- Bounded bursts give fair sharing; a per-requester rvalid tracks the RAM's 1-cycle synchronous read.

Parameters:
- ADDR_W, 8, address width of the RAM port.
- DATA_W, 8, data width of the RAM port.
- MAX_BURST, 4, max accepted accesses per tenure while the other requester waits (range 1..255).

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants an access; held until gnt0.
- we0  input  1  requester 0 access is a write (1) or read (0).
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- gnt0  output  1  requester 0 access accepted this cycle.
- rvalid0  output  1  rdata0 holds requester 0 read result.
- rdata0  output  DATA_W  read data for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1.
- ram_we  output  1  to RAM write_enable_A.
- ram_addr  output  ADDR_W  to RAM address_A.
- ram_din  output  DATA_W  to RAM data_in_A.
- ram_dout  input  DATA_W  from RAM data_out_A; valid 1 cycle after the address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=0, last_owner=1, beats=0, rvalid pipe=0.
  - All outputs 0: gnt*, rvalid*, ram_we, ram_addr, ram_din, rdata*.
  - Reset mid-burst drops any pending rvalid; no RAM write occurs while rst_n=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - No owner; RAM outputs driven 0.
  - If any req is high, the next edge sets BUSY and owner.
  - If only one req is high, owner = that requester.
  - If both are high, owner = !last_owner, so requester 0 wins the first contention after reset.
  - beats is cleared to 0.
- BUSY:
  - ram_we/ram_addr/ram_din are a combinational mux of the owner's we/addr/wdata, gated by req_owner; when req_owner=0 they are driven 0.
  - gnt_owner = req_owner, combinational; the non-owner's gnt=0.
  - Each accepted access (gnt=1) is one RAM operation in that cycle.
  - Latency: req rises in IDLE at cycle t → gnt at cycle t+1 → read data on rvalid at t+2.
  - An owner holding req in BUSY gets 1 access per cycle.
- Release is evaluated at each edge in BUSY:
  - Owner req=0: if other req=1, owner=other; else state=IDLE. Either way last_owner=old owner and beats=0.
  - Owner accepted an access with beats==MAX_BURST-1 and other req=1: owner=other next cycle, beats=0, last_owner=old owner.
  - Otherwise: on an accepted access beats=beats+1, saturating at MAX_BURST-1 when the other requester is idle. Owner is retained.
- Switching between owners has no idle cycle: a new owner gets gnt on the cycle after the switch edge.
- Read return:
  - A 1-bit pipe per requester records "accepted read" (gnt & !we); rvalidN is high on the following cycle.
  - rdata0 = rdata1 = ram_dout, combinational broadcast, meaningful only with rvalid.
  - Writes never raise rvalid.
- Write then read of the same address on consecutive cycles: the read returns the newly written data (RAM registered read, write precedes read).
- Requester protocol:
  - we/addr/wdata must be stable while req=1 and gnt=0.
  - Dropping req before gnt is legal; no access is issued.
- Port B of the RAM is not touched by this block.

Test Plan:
- Reset then req0=1, we0=1, addr0=0x05, wdata0=0xA5 for one access → gnt0 the cycle after req, ram_we=1 with addr 0x05/0xA5 in that cycle. Then req0=0 → IDLE, all RAM outputs 0.
- After the write above, req1 reads addr 0x05 → gnt1 one cycle after req1, rvalid1=1 with rdata1=0xA5 the cycle after; rvalid0 stays 0.
- Both req held continuously from IDLE after reset, MAX_BURST=4:
  - Grant order 0,0,0,0,1,1,1,1,0,…
  - No idle cycle at switches.
  - Exactly 4 gnt per tenure.
- req0 held alone for 10 cycles → 10 consecutive gnt0, with no forced release. Then req1 rises → at most 4 further gnt0 before gnt1.
- Write 0x3C to addr 0xFF, then read addr 0xFF on the next cycle → rvalid=1 with rdata=0x3C.
- rst_n pulsed low asynchronously mid-clock during a read burst:
  - gnt*, rvalid*, ram_we drop to 0 immediately.
  - After release, with both requesting, requester 0 wins first.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: two-requester handshake plus RAM port A signals for bram_port_arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, ram_we, ram_addr, ram_din
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of RAM port A between two requesters with bounded bursts.
module bram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  bram_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);
  state_t            r_state;
  logic              r_owner, r_last, r_rv0, r_rv1;
  logic [7:0]        r_beats;
  logic              w_req_own, w_req_oth, w_acc, w_gnt0, w_gnt1, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  always_comb begin
    w_req_own = r_owner ? bus.req1 : bus.req0;
    w_req_oth = r_owner ? bus.req0 : bus.req1;
    w_acc     = (r_state == BUSY) && w_req_own;
    w_gnt0    = w_acc && !r_owner;
    w_gnt1    = w_acc && r_owner;
    w_we      = w_acc && (r_owner ? bus.we1 : bus.we0);
    w_addr    = w_acc ? (r_owner ? bus.addr1 : bus.addr0) : '0;
    w_din     = w_acc ? (r_owner ? bus.wdata1 : bus.wdata0) : '0;
  end
  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.ram_we   = w_we;
  assign bus.ram_addr = w_addr;
  assign bus.ram_din  = w_din;
  assign bus.rvalid0  = r_rv0;
  assign bus.rvalid1  = r_rv1;
  assign bus.rdata0   = rst_n ? bus.ram_dout : '0;
  assign bus.rdata1   = rst_n ? bus.ram_dout : '0;
  // beats saturates at LAST so a late-arriving competitor waits at most one more access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_rv0 <= w_gnt0 && !bus.we0;
      r_rv1 <= w_gnt1 && !bus.we1;
      if (r_state == IDLE) begin
        r_beats <= '0;
        if (bus.req0 || bus.req1) begin
          r_state <= BUSY;
          r_owner <= (bus.req0 && bus.req1) ? !r_last : bus.req1;
        end
      end else if (!w_req_own) begin
        r_last  <= r_owner;
        r_beats <= '0;
        if (w_req_oth) r_owner <= !r_owner;
        else r_state <= IDLE;
      end else if (r_beats == LAST && w_req_oth) begin
        r_owner <= !r_owner;
        r_last  <= r_owner;
        r_beats <= '0;
      end else if (r_beats != LAST) begin
        r_beats <= r_beats + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and randomized checks against a tenure-count reference model.
module tb_bram_port_arbiter;
  localparam int AW = 8, DW = 8, MB = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] ram_mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end
  wire [18:0] d_port = {bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_din};
  wire [1:0]  d_rv   = {bus.rvalid0, bus.rvalid1};
  // reference model: owner -1 means nobody, m_cnt counts grants in the current tenure
  int         m_owner, m_cnt;
  bit         m_last;
  bit         m_rv [2];
  logic [7:0] m_rd [2];
  logic [7:0] m_mem [256];
  bit         e_gnt [2];
  bit         e_we;
  logic [7:0] e_addr, e_din;
  logic [18:0] e_port;
  logic [1:0]  e_rv;
  function automatic bit q_req(int i);
    return i == 1 ? bus.req1 : bus.req0;
  endfunction
  function automatic bit q_we(int i);
    return i == 1 ? bus.we1 : bus.we0;
  endfunction
  function automatic logic [7:0] q_addr(int i);
    return i == 1 ? bus.addr1 : bus.addr0;
  endfunction
  function automatic logic [7:0] q_wd(int i);
    return i == 1 ? bus.wdata1 : bus.wdata0;
  endfunction
  task automatic model_reset();
    m_owner = -1;
    m_cnt = 0;
    m_last = 1'b1;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
  endtask
  task automatic model_eval();
    e_gnt[0] = 1'b0;
    e_gnt[1] = 1'b0;
    e_we = 1'b0;
    e_addr = '0;
    e_din = '0;
    if (m_owner >= 0 && q_req(m_owner)) begin
      e_gnt[m_owner] = 1'b1;
      e_we = q_we(m_owner);
      e_addr = q_addr(m_owner);
      e_din = q_wd(m_owner);
    end
    e_port = {e_gnt[0], e_gnt[1], e_we, e_addr, e_din};
    e_rv = {m_rv[0], m_rv[1]};
  endtask
  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = e_gnt[i] && !q_we(i);
      if (m_rv[i]) m_rd[i] = m_mem[q_addr(i)];
    end
    if (e_we) m_mem[e_addr] = e_din;
    if (m_owner < 0) begin
      if (q_req(0) || q_req(1)) begin
        m_owner = (q_req(0) && q_req(1)) ? (m_last ? 0 : 1) : (q_req(0) ? 0 : 1);
        m_cnt = 0;
      end
    end else if (!q_req(m_owner)) begin
      m_last = (m_owner == 1);
      m_cnt = 0;
      m_owner = q_req(1 - m_owner) ? 1 - m_owner : -1;
    end else begin
      m_cnt++;
      if (m_cnt >= MB && q_req(1 - m_owner)) begin
        m_last = (m_owner == 1);
        m_owner = 1 - m_owner;
        m_cnt = 0;
      end
    end
  endtask
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask
  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(int i, bit r, bit w, logic [7:0] a, logic [7:0] d);
    if (i == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask
  task automatic idle_inputs();
    set_in(0, 0, 0, 8'h00, 8'h00);
    set_in(1, 0, 0, 8'h00, 8'h00);
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_reset();
    set_in(0, 1, 1, 8'h11, 8'h22);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (d_port !== 19'h0) begin errors++; $display("FAIL reset_port got=%h exp=0", d_port); end
    checks++;
    if (d_rv !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", d_rv); end
    checks++;
    if ({bus.rdata0, bus.rdata1} !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {bus.rdata0, bus.rdata1}); end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_write_read();
    set_in(0, 1, 1, 8'h05, 8'hA5);
    sample();
    checks++;
    if (d_port !== e_port) begin errors++; $display("FAIL wr_req_cycle got=%h exp=%h", d_port, e_port); end
    advance();
    sample();
    checks++;
    if (d_port !== {1'b1, 1'b0, 1'b1, 8'h05, 8'hA5}) begin errors++; $display("FAIL wr_grant got=%h exp=%h", d_port, {1'b1, 1'b0, 1'b1, 8'h05, 8'hA5}); end
    advance();
    bus.req0 = 1'b0;
    sample();
    checks++;
    if (d_port !== 19'h0) begin errors++; $display("FAIL wr_release got=%h exp=0", d_port); end
    advance();
    set_in(1, 1, 0, 8'h05, 8'h00);
    sample();
    checks++;
    if (d_port !== e_port) begin errors++; $display("FAIL rd_req_cycle got=%h exp=%h", d_port, e_port); end
    advance();
    sample();
    checks++;
    if (d_port !== {1'b0, 1'b1, 1'b0, 8'h05, 8'h00}) begin errors++; $display("FAIL rd_grant got=%h exp=%h", d_port, {1'b0, 1'b1, 1'b0, 8'h05, 8'h00}); end
    advance();
    bus.req1 = 1'b0;
    sample();
    checks++;
    if (d_rv !== 2'b01 || bus.rdata1 !== 8'hA5) begin errors++; $display("FAIL rd_return rv=%b data=%h exp rv=01 data=a5", d_rv, bus.rdata1); end
    advance();
  endtask
  task automatic test_contention();
    pulse_reset();
    set_in(0, 1, 0, 8'($urandom_range(255)), 8'h00);
    set_in(1, 1, 0, 8'($urandom_range(255)), 8'h00);
    for (int k = 0; k < 21; k++) begin
      sample();
      checks++;
      if (d_port !== e_port || d_rv !== e_rv) begin errors++; $display("FAIL contend_model k=%0d got=%h/%b exp=%h/%b", k, d_port, d_rv, e_port, e_rv); end
      if (k > 0) begin
        checks++;
        if ({bus.gnt0, bus.gnt1} !== ((((k - 1) / MB) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contend_order k=%0d got=%b", k, {bus.gnt0, bus.gnt1});
        end
      end
      advance();
      bus.addr0 = 8'($urandom_range(255));
      bus.addr1 = 8'($urandom_range(255));
    end
    idle_inputs();
    repeat (2) begin sample(); advance(); end
  endtask
  task automatic test_long_burst();
    int n0, extra;
    bit seen1;
    n0 = 0; extra = 0; seen1 = 0;
    set_in(0, 1, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    for (int k = 0; k < 11; k++) begin
      sample();
      checks++;
      if (d_port !== e_port) begin errors++; $display("FAIL solo_model k=%0d got=%h exp=%h", k, d_port, e_port); end
      n0 += int'(bus.gnt0);
      advance();
      set_in(0, 1, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    end
    checks++;
    if (n0 !== 10) begin errors++; $display("FAIL solo_count got=%0d exp=10", n0); end
    set_in(1, 1, 0, 8'h40, 8'h00);
    for (int k = 0; k < 8 && !seen1; k++) begin
      sample();
      checks++;
      if (d_port !== e_port) begin errors++; $display("FAIL late_model k=%0d got=%h exp=%h", k, d_port, e_port); end
      if (bus.gnt1) seen1 = 1'b1;
      else extra += int'(bus.gnt0);
      advance();
    end
    checks++;
    if (!seen1 || extra > MB) begin errors++; $display("FAIL late_switch seen=%0b extra=%0d exp seen=1 extra<=%0d", seen1, extra, MB); end
    idle_inputs();
    repeat (3) begin sample(); advance(); end
  endtask
  task automatic test_boundary_ff();
    set_in(0, 1, 1, 8'hFF, 8'h3C);
    sample();
    advance();
    sample();
    checks++;
    if (d_port !== {1'b1, 1'b0, 1'b1, 8'hFF, 8'h3C}) begin errors++; $display("FAIL ff_write got=%h", d_port); end
    advance();
    set_in(0, 1, 0, 8'hFF, 8'h00);
    sample();
    advance();
    bus.req0 = 1'b0;
    sample();
    checks++;
    if (d_rv !== 2'b10 || bus.rdata0 !== 8'h3C) begin errors++; $display("FAIL ff_readback rv=%b data=%h exp rv=10 data=3c", d_rv, bus.rdata0); end
    advance();
  endtask
  task automatic test_random();
    bit lastg [2];
    lastg[0] = 1'b0;
    lastg[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if (!(q_req(i) && !lastg[i] && $urandom_range(7) != 0))
          set_in(i, $urandom_range(3) != 0, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom_range(255)));
      sample();
      checks++;
      if (d_port !== e_port || d_rv !== e_rv) begin errors++; $display("FAIL rand_port c=%0d got=%h/%b exp=%h/%b", c, d_port, d_rv, e_port, e_rv); end
      if (m_rv[0]) begin
        checks++;
        if (bus.rdata0 !== m_rd[0]) begin errors++; $display("FAIL rand_rdata0 c=%0d got=%h exp=%h", c, bus.rdata0, m_rd[0]); end
      end
      if (m_rv[1]) begin
        checks++;
        if (bus.rdata1 !== m_rd[1]) begin errors++; $display("FAIL rand_rdata1 c=%0d got=%h exp=%h", c, bus.rdata1, m_rd[1]); end
      end
      lastg[0] = e_gnt[0];
      lastg[1] = e_gnt[1];
      advance();
    end
    idle_inputs();
    repeat (2) begin sample(); advance(); end
  endtask
  task automatic test_async_reset();
    set_in(0, 1, 0, 8'h05, 8'h00);
    set_in(1, 1, 0, 8'hFF, 8'h00);
    repeat (3) begin sample(); advance(); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_we} !== 5'b0) begin
      errors++; $display("FAIL async_drop got=%b exp=00000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_we});
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    model_eval();
    advance();
    sample();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10 || d_port !== e_port) begin errors++; $display("FAIL async_first got=%h exp=%h", d_port, e_port); end
    advance();
    idle_inputs();
  endtask
  initial begin
    for (int a = 0; a < 256; a++) begin
      ram_mem[a] = 8'h00;
      m_mem[a] = 8'h00;
    end
    idle_inputs();
    model_reset();
    test_reset();
    test_write_read();
    test_contention();
    test_long_burst();
    test_boundary_ff();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
